// File: rtl/uart_rx_deserializer_if.sv
// Byte-side bus of the UART receive deserializer: received data plus status strobes.
interface uart_rx_deserializer_if;

    logic [7:0] data_o;       // last correctly received byte
    logic       valid_o;      // one-cycle strobe: data_o just updated
    logic       frame_err_o;  // one-cycle strobe: stop bit sampled low
    logic       busy_o;       // receiver is inside a frame or waiting out a break

    // Receiver drives the bus.
    modport master (
        output data_o,
        output valid_o,
        output frame_err_o,
        output busy_o
    );

    // Byte consumer (register file, FIFO) observes the bus.
    modport slave (
        input data_o,
        input valid_o,
        input frame_err_o,
        input busy_o
    );

endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 8N1, LSB first, idle-high line.
// Samples the start bit at mid-bit, then every data/stop bit one bit period later,
// and reports each frame as either a valid byte or a framing error.
module uart_rx_deserializer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          rx_i,
    uart_rx_deserializer_if.master        rx_if
);

    localparam int unsigned N         = CLKS_PER_BIT;
    localparam int unsigned H         = N / 2;
    localparam int unsigned CNT_W     = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned DATA_W    = 8;

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;

    state_e state_q;
    state_e state_d;

    logic              rx_meta_q;
    logic              rx_s_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              frame_err_q;
    logic              busy_q;

    logic              half_pt;
    logic              bit_pt;

    logic              cnt_clr;
    logic              cnt_run;
    logic              idx_clr;
    logic              shift_en;
    logic              load_en;
    logic              err_en;
    logic              busy_d;

    // Mid-start-bit and end-of-bit-period sample points.
    assign half_pt = (cnt_q == CNT_HALF_LAST);
    assign bit_pt  = (cnt_q == CNT_BIT_LAST);

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: frame sequencing from the synchronized line.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // A start bit that is high again at mid-bit is a glitch.
                if (half_pt) begin
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_pt && (idx_q == IDX_LAST)) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_pt) begin
                    state_d = rx_s_q ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // Hold off until the line is released so a break is not seen as a start bit.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/control decode: counter, shift, load and strobe enables.
    always_comb begin
        cnt_clr  = 1'b0;
        cnt_run  = 1'b0;
        idx_clr  = 1'b0;
        shift_en = 1'b0;
        load_en  = 1'b0;
        err_en   = 1'b0;
        busy_d   = (state_d != S_IDLE);

        if (state_d != state_q) begin
            cnt_clr = 1'b1;
            idx_clr = 1'b1;
        end

        unique case (state_q)
            S_START: begin
                cnt_run = 1'b1;
            end
            S_DATA: begin
                cnt_run = 1'b1;
                if (bit_pt) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                end
            end
            S_STOP: begin
                cnt_run = 1'b1;
                if (bit_pt) begin
                    cnt_clr = 1'b1;
                    load_en = rx_s_q;
                    err_en  = !rx_s_q;
                end
            end
            default: begin
                cnt_run = 1'b0;
            end
        endcase
    end

    // Line synchronizer, bit timing, shift register and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            sr_q        <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;

            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_run) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (idx_clr) begin
                idx_q <= '0;
            end else if (shift_en) begin
                idx_q <= idx_q + IDX_W'(1);
            end

            // LSB arrives first, so new bits enter at the top and move down.
            if (shift_en) begin
                sr_q <= {rx_s_q, sr_q[DATA_W-1:1]};
            end

            if (load_en) begin
                data_q <= sr_q;
            end

            valid_q     <= load_en;
            frame_err_q <= err_en;
            busy_q      <= busy_d;
        end
    end

    // Drive the byte-side bus.
    assign rx_if.data_o      = data_q;
    assign rx_if.valid_o     = valid_q;
    assign rx_if.frame_err_o = frame_err_q;
    assign rx_if.busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frame scenarios at N=16 and a random
// byte stream at N=4, checked against expected bytes and spec-derived edge times.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

    localparam int N16   = 16;
    localparam int H16   = N16 / 2;
    localparam int N4    = 4;
    localparam int H4    = N4 / 2;
    // Output strobe is seen in the cycle after edge e0 + 2 + H + 9N.
    localparam int STOP16 = 2 + H16 + 9 * N16;
    localparam int STOP4  = 2 + H4 + 9 * N4;
    localparam int NRAND  = 200;

    logic clk = 1'b0;
    logic reset16;
    logic reset4;
    logic rx16;
    logic rx4;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    uart_rx_deserializer_if if16 ();
    uart_rx_deserializer_if if4 ();

    uart_rx_deserializer #(.CLKS_PER_BIT(N16)) dut16 (
        .clk_i   (clk),
        .reset_i (reset16),
        .rx_i    (rx16),
        .rx_if   (if16)
    );

    uart_rx_deserializer #(.CLKS_PER_BIT(N4)) dut4 (
        .clk_i   (clk),
        .reset_i (reset4),
        .rx_i    (rx4),
        .rx_if   (if4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Observation logs for the N=16 instance (cycle = edge count just before the sample).
    int v16_cyc[$];
    int v16_dat[$];
    int f16_cyc[$];
    int br16[$];
    int bf16[$];
    logic busy16_prev = 1'b0;
    logic mon16_en = 1'b0;

    always @(negedge clk) begin
        if (mon16_en) begin
            if (if16.valid_o) begin
                v16_cyc.push_back(cyc);
                v16_dat.push_back(int'(if16.data_o));
            end
            if (if16.frame_err_o) f16_cyc.push_back(cyc);
            if (if16.valid_o && if16.frame_err_o) check("n16_valid_ferr_exclusive", 32'd1, 32'd0);
            if (if16.busy_o && !busy16_prev) br16.push_back(cyc);
            if (!if16.busy_o && busy16_prev) bf16.push_back(cyc);
        end
        busy16_prev = if16.busy_o;
    end

    task automatic clear16();
        v16_cyc.delete();
        v16_dat.delete();
        f16_cyc.delete();
        br16.delete();
        bf16.delete();
    endtask

    // Reference for the N=4 stream: bytes and strobe times in send order.
    int exp4_dat[$];
    int exp4_cyc[$];
    int n4_rx = 0;
    int n4_ferr = 0;
    logic mon4_en = 1'b0;
    int pop_d;
    int pop_c;

    always @(negedge clk) begin
        if (mon4_en) begin
            if (if4.valid_o) begin
                n4_rx++;
                if (exp4_dat.size() == 0) begin
                    check("n4_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    pop_d = exp4_dat.pop_front();
                    pop_c = exp4_cyc.pop_front();
                    check("n4_data", 32'(if4.data_o), 32'(pop_d));
                    check("n4_valid_cycle", 32'(cyc), 32'(pop_c));
                end
            end
            if (if4.frame_err_o) n4_ferr++;
        end
    end

    // Line drivers: called #1 after an edge, return #1 after the last held edge.
    task automatic line16(input logic v, input int cycles);
        rx16 = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic line4(input logic v, input int cycles);
        rx4 = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic frame16(input logic [7:0] b, input logic stop, output int e0);
        e0 = cyc + 1;
        line16(1'b0, N16);
        for (int i = 0; i < 8; i++) line16(b[i], N16);
        line16(stop, N16);
    endtask

    task automatic frame4(input logic [7:0] b);
        exp4_dat.push_back(int'(b));
        exp4_cyc.push_back(cyc + 1 + STOP4);
        line4(1'b0, N4);
        for (int i = 0; i < 8; i++) line4(b[i], N4);
        line4(1'b1, N4);
    endtask

    int e0;
    int e1;
    int t0;
    logic [7:0] last16;
    logic [7:0] rb;
    logic [7:0] ab;
    int gap;

    initial begin
        reset16 = 1'b1;
        reset4  = 1'b1;
        rx16    = 1'b1;
        rx4     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset16 = 1'b0;
        reset4  = 1'b0;

        // Reset state of both instances.
        check("rst16_data",  32'(if16.data_o), 32'h0);
        check("rst16_valid", 32'(if16.valid_o), 32'h0);
        check("rst16_ferr",  32'(if16.frame_err_o), 32'h0);
        check("rst16_busy",  32'(if16.busy_o), 32'h0);
        check("rst4_data",   32'(if4.data_o), 32'h0);
        check("rst4_busy",   32'(if4.busy_o), 32'h0);
        last16 = 8'h00;

        line16(1'b1, 2 * N16);
        clear16();
        mon16_en = 1'b1;

        // Single frame 0xA5 with exact strobe and busy timing.
        frame16(8'hA5, 1'b1, e0);
        line16(1'b1, 2 * N16);
        last16 = 8'hA5;
        check("a5_valid_count", 32'(v16_cyc.size()), 32'd1);
        check("a5_valid_cycle", 32'(qget(v16_cyc, 0)), 32'(e0 + STOP16));
        check("a5_data_strobe", 32'(qget(v16_dat, 0)), 32'hA5);
        check("a5_ferr_count",  32'(f16_cyc.size()), 32'd0);
        check("a5_data_hold",   32'(if16.data_o), 32'(last16));
        check("a5_busy_rise",   32'(qget(br16, 0)), 32'(e0 + 2));
        check("a5_busy_fall",   32'(qget(bf16, 0)), 32'(e0 + STOP16));

        // Back-to-back 0x00 then 0xFF, no idle gap.
        clear16();
        frame16(8'h00, 1'b1, e0);
        frame16(8'hFF, 1'b1, e1);
        line16(1'b1, 2 * N16);
        last16 = 8'hFF;
        check("b2b_valid_count", 32'(v16_cyc.size()), 32'd2);
        check("b2b_first_cycle", 32'(qget(v16_cyc, 0)), 32'(e0 + STOP16));
        check("b2b_spacing",     32'(qget(v16_cyc, 1) - qget(v16_cyc, 0)), 32'(10 * N16));
        check("b2b_first_data",  32'(qget(v16_dat, 0)), 32'h00);
        check("b2b_second_data", 32'(qget(v16_dat, 1)), 32'hFF);
        check("b2b_ferr_count",  32'(f16_cyc.size()), 32'd0);

        // 3-cycle low glitch: busy for H cycles, no strobes.
        clear16();
        e0 = cyc + 1;
        line16(1'b0, 3);
        line16(1'b1, 3 * N16);
        check("glitch_valid_count", 32'(v16_cyc.size()), 32'd0);
        check("glitch_ferr_count",  32'(f16_cyc.size()), 32'd0);
        check("glitch_data_hold",   32'(if16.data_o), 32'(last16));
        check("glitch_busy_rise",   32'(qget(br16, 0)), 32'(e0 + 2));
        check("glitch_busy_len",    32'(qget(bf16, 0) - qget(br16, 0)), 32'(H16));

        // Framing error on 0x3C followed by a held-low line.
        clear16();
        frame16(8'h3C, 1'b0, e0);
        line16(1'b0, 40);
        t0 = cyc;
        line16(1'b1, 3 * N16);
        check("ferr_count",        32'(f16_cyc.size()), 32'd1);
        check("ferr_cycle",        32'(qget(f16_cyc, 0)), 32'(e0 + STOP16));
        check("ferr_valid_count",  32'(v16_cyc.size()), 32'd0);
        check("ferr_data_hold",    32'(if16.data_o), 32'(last16));
        check("ferr_busy_rises",   32'(br16.size()), 32'd1);
        check("ferr_busy_fall",    32'(qget(bf16, 0)), 32'(t0 + 3));

        // Reset pulse in the middle of data bit 4.
        clear16();
        ab = 8'h6B;
        line16(1'b0, N16);
        for (int i = 0; i < 4; i++) line16(ab[i], N16);
        line16(ab[4], H16);
        reset16 = 1'b1;
        @(posedge clk);
        #1;
        reset16 = 1'b0;
        rx16    = 1'b1;
        last16  = 8'h00;
        check("midrst_data",  32'(if16.data_o), 32'h0);
        check("midrst_valid", 32'(if16.valid_o), 32'h0);
        check("midrst_ferr",  32'(if16.frame_err_o), 32'h0);
        check("midrst_busy",  32'(if16.busy_o), 32'h0);
        line16(1'b1, 2 * N16);
        check("midrst_no_valid", 32'(v16_cyc.size()), 32'd0);
        check("midrst_no_ferr",  32'(f16_cyc.size()), 32'd0);

        clear16();
        frame16(8'h5A, 1'b1, e0);
        line16(1'b1, 2 * N16);
        check("post_rst_count", 32'(v16_cyc.size()), 32'd1);
        check("post_rst_cycle", 32'(qget(v16_cyc, 0)), 32'(e0 + STOP16));
        check("post_rst_data",  32'(qget(v16_dat, 0)), 32'h5A);
        check("post_rst_ferr",  32'(f16_cyc.size()), 32'd0);

        // Random stream at the minimum bit period.
        line4(1'b1, 4 * N4);
        mon4_en = 1'b1;
        for (int k = 0; k < NRAND; k++) begin
            rb  = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            frame4(rb);
            if (gap > 0) line4(1'b1, gap * N4);
        end
        line4(1'b1, 4 * N4);
        check("n4_rx_count",   32'(n4_rx), 32'(NRAND));
        check("n4_pending",    32'(exp4_dat.size()), 32'd0);
        check("n4_ferr_count", 32'(n4_ferr), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
